// File: rtl/diff_freq_serial_in.sv
// diff_freq_serial_in
//   Receiver for a pulse-width coded serial line. A short high pulse
//   (shorter than THRESH clocks) is a 1, and a long one is a 0. Bits are
//   packed LSB-first into DATA_BIT-wide words. Each word goes to a UART
//   transmitter through its tx_start/tx_done handshake. A one-word holding
//   register absorbs a word that arrives while the transmitter is busy.
//
// Ports
//   clk_i          system clock
//   rst_ni         asynchronous active-low reset
//   serial_i       asynchronous serial line (synchronised internally)
//   tx_done_tick_i UART finished the current byte (1-cycle pulse)
//   data_o         byte for the UART (held between launches)
//   tx_start_o     1-cycle pulse launching a UART transmission
//   frame_err_o    1-cycle pulse: glitch, stuck-high line or partial frame
//   overrun_o      1-cycle pulse: word dropped because the holding register was full
//
// Optional build macro DIFF_FREQ_SERIAL_IN_STATS_EN adds:
//   byte_cnt_o     wrapping count of tx_start_o pulses
//   err_cnt_o      saturating count of cycles with frame_err_o or overrun_o

module diff_freq_serial_in #(
    parameter int unsigned DATA_BIT     = 8,
    parameter int unsigned SLOW_PERIOD  = 40,
    parameter int unsigned FAST_PERIOD  = 10,
    parameter int unsigned MIN_WIDTH    = 2,
    parameter int unsigned IDLE_TIMEOUT = 80,
    parameter int unsigned CNT_WIDTH    = 16
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                serial_i,
    input  logic                tx_done_tick_i,
    output logic [DATA_BIT-1:0] data_o,
    output logic                tx_start_o,
    output logic                frame_err_o,
    output logic                overrun_o
`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
    ,
    output logic [15:0]         byte_cnt_o,
    output logic [15:0]         err_cnt_o
`endif
);

    // Midpoint between the two high-pulse widths (half of each full period).
    localparam int unsigned THRESH = (SLOW_PERIOD + FAST_PERIOD) / 4;
    localparam int unsigned IDX_W  = (DATA_BIT > 1) ? $clog2(DATA_BIT) : 1;

    localparam logic [CNT_WIDTH-1:0] SLOW_CNT   = CNT_WIDTH'(SLOW_PERIOD);
    localparam logic [CNT_WIDTH-1:0] THRESH_CNT = CNT_WIDTH'(THRESH);
    localparam logic [CNT_WIDTH-1:0] MIN_CNT    = CNT_WIDTH'(MIN_WIDTH);
    localparam logic [CNT_WIDTH-1:0] IDLE_CNT   = CNT_WIDTH'(IDLE_TIMEOUT);
    localparam logic [CNT_WIDTH-1:0] ONE_CNT    = CNT_WIDTH'(1);
    localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(DATA_BIT - 1);

    typedef enum logic [1:0] {
        StIdle,
        StHigh,
        StLow,
        StWaitLow
    } state_e;

    // ------------------------------------------------------------------
    // Input synchroniser and edge detect
    // ------------------------------------------------------------------
    logic sync1_q, sync2_q, s_prev_q;
    logic s, rise;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            s_prev_q <= 1'b0;
        end else begin
            sync1_q  <= serial_i;
            sync2_q  <= sync1_q;
            s_prev_q <= sync2_q;
        end
    end

    assign s    = sync2_q;
    assign rise = s & ~s_prev_q;

    // ------------------------------------------------------------------
    // Symbol decoder FSM
    // ------------------------------------------------------------------
    state_e               state_q, state_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
    logic [DATA_BIT-1:0]  shift_q, shift_d;
    logic                 fsm_err;
    logic                 word_done;

    assign cnt_inc = cnt_q + ONE_CNT;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        fsm_err   = 1'b0;
        word_done = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (rise) begin
                    state_d = StHigh;
                    cnt_d   = ONE_CNT;
                end
            end

            StHigh: begin
                if (s) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == SLOW_CNT) begin
                        // Stuck high: drop the partial word, wait for the line to release.
                        fsm_err   = 1'b1;
                        bit_idx_d = '0;
                        state_d   = StWaitLow;
                    end
                end else if (cnt_q < MIN_CNT) begin
                    fsm_err   = 1'b1;
                    bit_idx_d = '0;
                    state_d   = StIdle;
                end else begin
                    shift_d[bit_idx_q] = (cnt_q < THRESH_CNT);
                    if (bit_idx_q == LAST_IDX) begin
                        bit_idx_d = '0;
                        word_done = 1'b1;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                    state_d = StLow;
                    cnt_d   = ONE_CNT;
                end
            end

            StLow: begin
                if (rise) begin
                    state_d = StHigh;
                    cnt_d   = ONE_CNT;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == IDLE_CNT) begin
                        state_d   = StIdle;
                        fsm_err   = (bit_idx_q != '0);
                        bit_idx_d = '0;
                    end
                end
            end

            StWaitLow: begin
                if (!s) begin
                    state_d = StIdle;
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
        end
    end

    // ------------------------------------------------------------------
    // UART hand-off with one-word holding register
    // ------------------------------------------------------------------
    logic [DATA_BIT-1:0] data_q, data_d;
    logic [DATA_BIT-1:0] hold_q, hold_d;
    logic                hold_full_q, hold_full_d;
    logic                tx_busy_q, tx_busy_d;
    logic                tx_start_q, tx_start_d;
    logic                overrun_q, overrun_d;
    logic                frame_err_q;
    logic                tx_free;

    assign tx_free = ~tx_busy_q | tx_done_tick_i;

    always_comb begin
        data_d      = data_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        tx_busy_d   = tx_busy_q;
        tx_start_d  = 1'b0;
        overrun_d   = 1'b0;

        if (tx_done_tick_i) begin
            tx_busy_d = 1'b0;
        end

        if (hold_full_q && tx_free) begin
            // Held byte goes first; a word completing now takes its place.
            data_d      = hold_q;
            tx_start_d  = 1'b1;
            tx_busy_d   = 1'b1;
            hold_full_d = 1'b0;
            if (word_done) begin
                hold_d      = shift_d;
                hold_full_d = 1'b1;
            end
        end else if (word_done) begin
            if (tx_free) begin
                data_d     = shift_d;
                tx_start_d = 1'b1;
                tx_busy_d  = 1'b1;
            end else if (!hold_full_q) begin
                hold_d      = shift_d;
                hold_full_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            data_q      <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            tx_busy_q   <= 1'b0;
            tx_start_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            data_q      <= data_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            tx_busy_q   <= tx_busy_d;
            tx_start_q  <= tx_start_d;
            overrun_q   <= overrun_d;
            frame_err_q <= fsm_err;
        end
    end

    assign data_o      = data_q;
    assign tx_start_o  = tx_start_q;
    assign frame_err_o = frame_err_q;
    assign overrun_o   = overrun_q;

`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
    logic [15:0] byte_cnt_q, err_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            err_cnt_q  <= '0;
        end else begin
            if (tx_start_q) begin
                byte_cnt_q <= byte_cnt_q + 16'd1;
            end
            if ((frame_err_q || overrun_q) && (err_cnt_q != 16'hFFFF)) begin
                err_cnt_q <= err_cnt_q + 16'd1;
            end
        end
    end

    assign byte_cnt_o = byte_cnt_q;
    assign err_cnt_o  = err_cnt_q;
`endif

endmodule

// File: tb/tb_diff_freq_serial_in.sv
// Directed bench for diff_freq_serial_in: clean bytes, back-pressure with
// holding register and overrun, glitch, partial-frame timeout, stuck-high
// line and mid-byte reset. Fast symbol = high 5/low 5, slow = high 20/low 20.

module tb_diff_freq_serial_in;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       serial;
    logic       tx_done;
    logic [7:0] data;
    logic       tx_start;
    logic       frame_err;
    logic       overrun;
`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
    logic [15:0] byte_cnt;
    logic [15:0] err_cnt;
`endif

    diff_freq_serial_in dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .serial_i       (serial),
        .tx_done_tick_i (tx_done),
        .data_o         (data),
        .tx_start_o     (tx_start),
        .frame_err_o    (frame_err),
        .overrun_o      (overrun)
`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
        ,
        .byte_cnt_o     (byte_cnt),
        .err_cnt_o      (err_cnt)
`endif
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Event monitor, sampled on the inactive edge.
    int unsigned n_start = 0, n_err = 0, n_ovr = 0, n_viol = 0;
    int unsigned last_start_cyc = 0;
    logic [7:0]  last_data = '0;
    logic        prev_fe = 1'b0, prev_ov = 1'b0;

    always @(negedge clk) begin
        if (tx_start === 1'b1) begin
            n_start++;
            last_data      = data;
            last_start_cyc = cyc;
        end
        if (frame_err === 1'b1) n_err++;
        if (overrun === 1'b1) n_ovr++;
        if ((frame_err === 1'b1) && prev_fe) n_viol++;
        if ((overrun === 1'b1) && prev_ov) n_viol++;
        prev_fe = (frame_err === 1'b1);
        prev_ov = (overrun === 1'b1);
    end

    int unsigned tests = 0, fails = 0;
    int unsigned last_fall = 0, done_cyc = 0;
    int unsigned b_start, b_err, b_ovr;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_sym(input bit b);
        serial = 1'b1;
        tick(b ? 5 : 20);
        serial    = 1'b0;
        last_fall = cyc;
        tick(b ? 5 : 20);
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 0; i < 8; i++) send_sym(v[i]);
    endtask

    task automatic pulse_done();
        tx_done  = 1'b1;
        done_cyc = cyc;
        tick(1);
        tx_done  = 1'b0;
    endtask

    task automatic mark();
        b_start = n_start;
        b_err   = n_err;
        b_ovr   = n_ovr;
    endtask

    initial begin
        rst_n   = 1'b0;
        serial  = 1'b0;
        tx_done = 1'b0;
        tick(3);
        #1;
        check_eq("rst_tx_start", {31'd0, tx_start}, 32'd0);
        check_eq("rst_frame_err", {31'd0, frame_err}, 32'd0);
        check_eq("rst_overrun", {31'd0, overrun}, 32'd0);
        check_eq("rst_data", {24'd0, data}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);

        // 1: clean byte, latency from last serial fall
        mark();
        send_byte(8'hA5);
        tick(5);
        check_eq("s1_starts", n_start - b_start, 32'd1);
        check_eq("s1_data", {24'd0, last_data}, 32'hA5);
        check_eq("s1_latency", last_start_cyc - last_fall, 32'd3);
        check_eq("s1_no_err", n_err - b_err, 32'd0);
        pulse_done();
        tick(2);

        // 2: back-pressure: launch, hold, drop
        mark();
        send_byte(8'h3C);
        send_byte(8'hFF);
        send_byte(8'h00);
        tick(5);
        check_eq("s2_starts", n_start - b_start, 32'd1);
        check_eq("s2_data_3c", {24'd0, data}, 32'h3C);
        check_eq("s2_overrun", n_ovr - b_ovr, 32'd1);
        check_eq("s2_no_err", n_err - b_err, 32'd0);
        pulse_done();
        tick(3);
        check_eq("s2_held_start", n_start - b_start, 32'd2);
        check_eq("s2_held_data", {24'd0, last_data}, 32'hFF);
        check_eq("s2_held_latency", last_start_cyc - done_cyc, 32'd1);
        pulse_done();
        tick(2);

        // 3: single-cycle glitch mid-byte, then clean byte
        mark();
        send_sym(1'b1);
        send_sym(1'b0);
        send_sym(1'b1);
        serial = 1'b1;
        tick(1);
        serial = 1'b0;
        tick(10);
        check_eq("s3_glitch_err", n_err - b_err, 32'd1);
        check_eq("s3_glitch_nostart", n_start - b_start, 32'd0);
        send_byte(8'h5A);
        tick(5);
        check_eq("s3_starts", n_start - b_start, 32'd1);
        check_eq("s3_data", {24'd0, last_data}, 32'h5A);
        check_eq("s3_err_total", n_err - b_err, 32'd1);
        pulse_done();
        tick(2);

        // 4: partial frame then idle timeout
        mark();
        send_sym(1'b1);
        send_sym(1'b0);
        send_sym(1'b1);
        tick(90);
        check_eq("s4_timeout_err", n_err - b_err, 32'd1);
        check_eq("s4_nostart", n_start - b_start, 32'd0);
        send_byte(8'h81);
        tick(5);
        check_eq("s4_starts", n_start - b_start, 32'd1);
        check_eq("s4_data", {24'd0, last_data}, 32'h81);
        check_eq("s4_err_total", n_err - b_err, 32'd1);
        pulse_done();
        tick(2);

        // 5: line stuck high, then recovery
        mark();
        serial = 1'b1;
        tick(50);
        serial = 1'b0;
        tick(10);
        check_eq("s5_stuck_err", n_err - b_err, 32'd1);
        check_eq("s5_nostart", n_start - b_start, 32'd0);
        check_eq("s5_noovr", n_ovr - b_ovr, 32'd0);
        send_byte(8'hE7);
        tick(5);
        check_eq("s5_data", {24'd0, last_data}, 32'hE7);
        check_eq("s5_starts", n_start - b_start, 32'd1);
        pulse_done();
        tick(2);
`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
        check_eq("stats_bytes", {16'd0, byte_cnt}, 32'd6);
        check_eq("stats_errs", {16'd0, err_cnt}, 32'd4);
`endif

        // 6: reset mid-byte
        mark();
        send_sym(1'b1);
        send_sym(1'b0);
        send_sym(1'b0);
        send_sym(1'b1);
        rst_n = 1'b0;
        #1;
        check_eq("s6_rst_data", {24'd0, data}, 32'd0);
        check_eq("s6_rst_start", {31'd0, tx_start}, 32'd0);
        check_eq("s6_rst_err", {31'd0, frame_err}, 32'd0);
        check_eq("s6_rst_ovr", {31'd0, overrun}, 32'd0);
`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
        check_eq("s6_rst_bytes", {16'd0, byte_cnt}, 32'd0);
        check_eq("s6_rst_errs", {16'd0, err_cnt}, 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        tick(5);
        send_byte(8'hC3);
        tick(5);
        check_eq("s6_starts", n_start - b_start, 32'd1);
        check_eq("s6_data", {24'd0, last_data}, 32'hC3);
        check_eq("s6_no_err", n_err - b_err, 32'd0);
`ifdef DIFF_FREQ_SERIAL_IN_STATS_EN
        check_eq("s6_bytes", {16'd0, byte_cnt}, 32'd1);
        check_eq("s6_errs", {16'd0, err_cnt}, 32'd0);
`endif
        check_eq("pulse_width", n_viol, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
